mult_seq: RTL and testbench
===========================

Name: mult_seq

Overview:
- Sequential shift-add signed multiplier that feeds the LED output stage.
- Accepts two DW-bit two's-complement operands on a start pulse and computes the product over DW iterations.
- Presents the result as a 2*DW-bit magnitude plus a separate sign bit, with o_stop flagging a valid, held result.
- o_product, o_sign and o_stop connect directly to the LED stage's i_product, i_sign and i_stop.

Parameters:
- DW, 8, operand width in bits (two's complement); product magnitude width is 2*DW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE or DONE.
- i_multiplicand  input  DW  operand A, two's complement.
- i_multiplier  input  DW  operand B, two's complement.
- o_product  output  2*DW  product magnitude |A*B|, registered.
- o_sign  output  1  product sign (1 = negative), registered.
- o_stop  output  1  result valid; held high until the next accepted start.
- o_busy  output  1  high while in LOAD or MULT.

Behaviour:
- Reset (async, rst=1): state=IDLE; o_product=0, o_sign=0, o_stop=0, o_busy=0; internal accumulator, shift registers and counter cleared.
- Reset asserted mid-operation aborts immediately to these values. The partial result is discarded.
- States:
  - IDLE: i_start=1 -> LOAD; otherwise stay.
  - LOAD (1 cycle):
    - Capture |A| and |B| as DW-bit magnitudes (|-2^(DW-1)| = 2^(DW-1) fits unsigned DW).
    - Capture sign = A[DW-1] XOR B[DW-1].
    - Clear the accumulator; counter=0 -> MULT.
  - MULT (exactly DW cycles):
    - Each cycle: if multiplier LSB=1, add the shifted multiplicand to the 2*DW accumulator.
    - Then shift the multiplicand left by 1 and the multiplier right by 1; counter+1.
    - After the DW-th iteration -> DONE.
    - No early termination on zero operands.
  - DONE:
    - On entry, register o_product=accumulator.
    - o_sign = sign AND (accumulator != 0); a zero product is never reported as negative.
    - o_stop=1 while in DONE.
    - i_start=1 -> LOAD. o_stop drops on the same edge, and o_product/o_sign hold their values until the next DONE entry.
- Latency: i_start sampled high at edge N -> o_stop high after edge N+DW+2 (DW=8: 10 cycles).
- i_start is ignored while o_busy=1. Operands only need to be stable on the edge that enters LOAD.
- i_start held continuously high: back-to-back multiplications, with o_stop high for exactly 1 cycle per result.
- No overflow is possible: the maximum magnitude 2^(2DW-2) fits in 2*DW bits. The accumulator adder is 2*DW bits wide with no carry-out.
- o_busy = (state==LOAD || state==MULT), decoded from registered state.

Test Plan:
- Reset then idle, no start -> o_product=0, o_sign=0, o_stop=0, o_busy=0 indefinitely.
- A=7, B=-3, 1-cycle start pulse -> o_busy high for 9 cycles; after 10 cycles o_stop=1, o_product=21, o_sign=1; values held while i_start=0.
- A=-128, B=-128 -> o_product=16384 (0x4000), o_sign=0. Then A=127, B=-128 -> o_product=16256, o_sign=1.
- A=0, B=-5 -> o_product=0, o_sign=0 (zero never negative); latency still 10 cycles.
- Start pulses while o_busy=1, with operands changed mid-run -> ignored; result matches the operands captured at LOAD.
- rst asserted during MULT (cycle 4), released, then A=12, B=12 started -> outputs 0 immediately on rst; next result o_product=144, o_sign=0, o_stop=1 after 10 cycles.

Source files
------------

// File: rtl/mult_seq_if.sv
// Operand/result bundle between a mult_seq client and the multiplier.
// Result side maps onto the LED stage's i_product/i_sign/i_stop.
interface mult_seq_if #(
  parameter int DW = 8
);
  logic                i_start;
  logic [DW-1:0]       i_multiplicand;
  logic [DW-1:0]       i_multiplier;
  logic [2*DW-1:0]     o_product;
  logic                o_sign;
  logic                o_stop;
  logic                o_busy;

  modport master (
    output i_start, i_multiplicand, i_multiplier,
    input  o_product, o_sign, o_stop, o_busy
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier,
    output o_product, o_sign, o_stop, o_busy
  );
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add signed multiplier: sign-magnitude operands,
// DW add/shift iterations, result held as magnitude + sign until the next start.
module mult_seq #(
  parameter int DW = 8
) (
  input  logic      clk,
  input  logic      rst,
  mult_seq_if.slave bus
);

  localparam int PW = 2 * DW;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     mcand_sh;
  logic [DW-1:0]     mplier_sh;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              sign_r;
  logic [PW-1:0]     product_r;
  logic              sign_out_r;
  logic              stop_r;

  logic signed [DW-1:0] op_a;
  logic signed [DW-1:0] op_b;
  logic [DW-1:0]        mag_a;
  logic [DW-1:0]        mag_b;
  logic                 sign_in;

  // The most negative operand maps to 2^(DW-1), which still fits unsigned DW.
  function automatic logic [DW-1:0] magnitude(input logic signed [DW-1:0] v);
    logic [DW-1:0] u;
    u = $unsigned(v);
    return v[DW-1] ? (~u + 1'b1) : u;
  endfunction

  always_comb begin
    op_a    = $signed(bus.i_multiplicand);
    op_b    = $signed(bus.i_multiplier);
    mag_a   = magnitude(op_a);
    mag_b   = magnitude(op_b);
    sign_in = op_a[DW-1] ^ op_b[DW-1];
  end

  // Operands are captured on the edge that enters LOAD; DONE presents the
  // result in its first cycle and only then accepts a new start, so a held
  // start still yields a one-cycle o_stop pulse per result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mcand_sh   <= '0;
      mplier_sh  <= '0;
      acc        <= '0;
      cnt        <= '0;
      sign_r     <= 1'b0;
      product_r  <= '0;
      sign_out_r <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            mcand_sh  <= {{DW{1'b0}}, mag_a};
            mplier_sh <= mag_b;
            sign_r    <= sign_in;
            state     <= LOAD;
          end
        end
        LOAD: begin
          acc   <= '0;
          cnt   <= '0;
          state <= MULT;
        end
        MULT: begin
          if (mplier_sh[0])
            acc <= acc + mcand_sh;
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_sh >> 1;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(DW - 1))
            state <= DONE;
        end
        DONE: begin
          if (!stop_r) begin
            product_r  <= acc;
            sign_out_r <= sign_r & (|acc);
            stop_r     <= 1'b1;
          end else if (bus.i_start) begin
            mcand_sh  <= {{DW{1'b0}}, mag_a};
            mplier_sh <= mag_b;
            sign_r    <= sign_in;
            stop_r    <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_product = product_r;
  assign bus.o_sign    = sign_out_r;
  assign bus.o_stop    = stop_r;
  assign bus.o_busy    = (state == LOAD) || (state == MULT);

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed vector table, randomized operands against an
// integer reference model, and hand-written busy-ignore / reset / back-to-back runs.
module tb_mult_seq;

  localparam int DW = 8;
  localparam int PW = 2 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_seq_if #(.DW(DW)) bus ();

  mult_seq #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    int                   exp_mag;
    logic                 exp_sign;
  } vec_t;

  vec_t table_v[8];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain signed integer product, split into magnitude and sign.
  task automatic model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                       output int mag, output logic s);
    int p;
    p   = int'(a) * int'(b);
    s   = (p < 0);
    mag = (p < 0) ? -p : p;
  endtask

  // Launch one multiplication, measure latency and busy cycles, check result and hold.
  task automatic run_check(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                           input int exp_mag, input logic exp_sign, input string name);
    int lat, busy_cnt;
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    busy_cnt = bus.o_busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_stop) begin
        lat = k;
        break;
      end
      if (bus.o_busy) busy_cnt++;
    end
    check({name, " latency"}, lat, 10);
    check({name, " busy_cycles"}, busy_cnt, 9);
    check({name, " product"}, int'(bus.o_product), exp_mag);
    check({name, " sign"}, int'(bus.o_sign), int'(exp_sign));
    repeat (3) @(posedge clk);
    #1;
    check({name, " stop_held"}, int'(bus.o_stop), 1);
    check({name, " product_held"}, int'(bus.o_product), exp_mag);
  endtask

  initial begin
    int   mag, stop_pulses, prev_stop, lat;
    logic s;
    logic signed [DW-1:0] ra, rb;

    table_v[0] = '{a:  8'sd7,    b: -8'sd3,    exp_mag: 21,    exp_sign: 1'b1};
    table_v[1] = '{a: -8'sd128,  b: -8'sd128,  exp_mag: 16384, exp_sign: 1'b0};
    table_v[2] = '{a:  8'sd127,  b: -8'sd128,  exp_mag: 16256, exp_sign: 1'b1};
    table_v[3] = '{a:  8'sd0,    b: -8'sd5,    exp_mag: 0,     exp_sign: 1'b0};
    table_v[4] = '{a:  8'sd12,   b:  8'sd12,   exp_mag: 144,   exp_sign: 1'b0};
    table_v[5] = '{a: -8'sd1,    b: -8'sd1,    exp_mag: 1,     exp_sign: 1'b0};
    table_v[6] = '{a: -8'sd128,  b:  8'sd127,  exp_mag: 16256, exp_sign: 1'b1};
    table_v[7] = '{a:  8'sd127,  b:  8'sd127,  exp_mag: 16129, exp_sign: 1'b0};

    bus.i_start        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle product", int'(bus.o_product), 0);
    check("idle sign", int'(bus.o_sign), 0);
    check("idle stop", int'(bus.o_stop), 0);
    check("idle busy", int'(bus.o_busy), 0);

    // Directed table
    foreach (table_v[i])
      run_check(table_v[i].a, table_v[i].b, table_v[i].exp_mag, table_v[i].exp_sign,
                $sformatf("vec%0d", i));

    // Randomized against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = $signed(DW'($urandom));
      rb = $signed(DW'($urandom));
      if (i % 10 == 3) ra = '0;
      model(ra, rb, mag, s);
      run_check(ra, rb, mag, s, $sformatf("rnd%0d(%0d*%0d)", i, ra, rb));
    end

    // Start requests while busy, with operands scrambled mid-run
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 8'sd9;
    bus.i_multiplier   = -8'sd7;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_stop) begin
        lat = k;
        break;
      end
      bus.i_start        = (k <= 6);
      bus.i_multiplicand = DW'($urandom);
      bus.i_multiplier   = DW'($urandom);
    end
    bus.i_start = 1'b0;
    check("busy_ignore latency", lat, 10);
    check("busy_ignore product", int'(bus.o_product), 63);
    check("busy_ignore sign", int'(bus.o_sign), 1);

    // Async reset during MULT
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 8'sd3;
    bus.i_multiplier   = 8'sd5;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid product", int'(bus.o_product), 0);
    check("rst_mid sign", int'(bus.o_sign), 0);
    check("rst_mid stop", int'(bus.o_stop), 0);
    check("rst_mid busy", int'(bus.o_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    run_check(8'sd12, 8'sd12, 144, 1'b0, "after_rst");

    // Start held high: back-to-back results, one-cycle stop pulses
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 8'sd5;
    bus.i_multiplier   = -8'sd6;
    stop_pulses = 0;
    prev_stop   = 1;
    @(posedge clk); #1;
    prev_stop = bus.o_stop;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_stop) begin
        if (prev_stop == 0) stop_pulses++;
        check("b2b stop_width", prev_stop, 0);
        check("b2b product", int'(bus.o_product), 30);
        check("b2b sign", int'(bus.o_sign), 1);
      end
      prev_stop = bus.o_stop;
    end
    bus.i_start = 1'b0;
    check("b2b pulses", stop_pulses, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
